// File: rtl/axis_debug_pkg.sv
// Shared types for the axis_debug interconnect.
// Timeout support is enabled with AXIS_DEBUG_INTERCONNECT_TIMEOUT_EN.
package axis_debug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } arb_state_t;

    localparam logic [7:0] AXIS_DEBUG_TIMEOUT_BYTE = 8'hEE;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_debug_interconnect_rr_arbiter.sv
// Round-robin next-grant search starting just after the last grant.
// Purely combinational; the caller registers the result.
module rr_arbiter
    import axis_debug_pkg::*;
#(
    parameter int N_PORTS = 4,
    localparam int IW = idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      grant,
    output logic               valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = IW'((int'(last_grant) + i) % N_PORTS);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/axis_debug_interconnect.sv
// Request broadcast and frame-level response merge for axis_debug devices.
// Define AXIS_DEBUG_INTERCONNECT_TIMEOUT_EN to abort stalled response frames.
module axis_debug_interconnect
    import axis_debug_pkg::*;
#(
    parameter int N_PORTS        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_s_axis_tvalid,
    output logic                   o_s_axis_tready,
    input  logic [7:0]             i_s_axis_tdata,
    input  logic                   i_s_axis_tlast,
    output logic                   o_m_axis_tvalid,
    input  logic                   i_m_axis_tready,
    output logic [7:0]             o_m_axis_tdata,
    output logic                   o_m_axis_tlast,
    output logic [N_PORTS-1:0]     o_req_axis_tvalid,
    input  logic [N_PORTS-1:0]     i_req_axis_tready,
    output logic [7:0]             o_req_axis_tdata,
    output logic                   o_req_axis_tlast,
    input  logic [N_PORTS-1:0]     i_rsp_axis_tvalid,
    output logic [N_PORTS-1:0]     o_rsp_axis_tready,
    input  logic [N_PORTS-1:0][7:0] i_rsp_axis_tdata,
    input  logic [N_PORTS-1:0]     i_rsp_axis_tlast
);

    localparam int IW = idx_w(N_PORTS);

    logic               full;
    logic [7:0]         fwd_data;
    logic               fwd_last;
    logic [N_PORTS-1:0] pending;
    logic [N_PORTS-1:0] pend_next;
    logic               load;

    assign o_req_axis_tvalid = full ? pending : '0;
    assign o_req_axis_tdata  = fwd_data;
    assign o_req_axis_tlast  = fwd_last;
    assign pend_next = pending & ~(o_req_axis_tvalid & i_req_axis_tready);
    assign o_s_axis_tready = !i_rst &&
        (!full || (pending & ~i_req_axis_tready) == '0);
    assign load = i_s_axis_tvalid && o_s_axis_tready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full     <= 1'b0;
            fwd_data <= '0;
            fwd_last <= 1'b0;
            pending  <= '0;
        end else if (load) begin
            full     <= 1'b1;
            fwd_data <= i_s_axis_tdata;
            fwd_last <= i_s_axis_tlast;
            pending  <= '1;
        end else if (full) begin
            pending <= pend_next;
            full    <= (pend_next != '0);
        end
    end

    arb_state_t    state;
    logic [IW-1:0] grant;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] arb_grant;
    logic          arb_valid;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;
    logic          slot_free;
    logic          g_valid;
    logic          g_last;
    logic          accept;
    logic          tmo;

    rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
        .req        (i_rsp_axis_tvalid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign slot_free = !out_valid || i_m_axis_tready;
    assign g_valid   = i_rsp_axis_tvalid[grant];
    assign g_last    = i_rsp_axis_tlast[grant];
    assign accept    = (state == BUSY) && g_valid && slot_free;

    assign o_m_axis_tvalid = out_valid;
    assign o_m_axis_tdata  = out_data;
    assign o_m_axis_tlast  = out_last;

    always_comb begin
        o_rsp_axis_tready = '0;
        if (state == BUSY)
            o_rsp_axis_tready[grant] = slot_free;
        if (state == DRAIN)
            o_rsp_axis_tready[grant] = 1'b1;
    end

`ifdef AXIS_DEBUG_INTERCONNECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;

    assign tmo = (state == BUSY) && !g_valid && slot_free &&
                 (stall_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            stall_cnt <= '0;
        else if (state != BUSY || accept)
            stall_cnt <= '0;
        else if (!g_valid && stall_cnt != TW'(TIMEOUT_CYCLES))
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(N_PORTS - 1);
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= i_rsp_axis_tdata[grant];
                out_last  <= g_last;
            end else if (tmo) begin
                // Synthesised terminator so the host sees a closed frame
                out_valid <= 1'b1;
                out_data  <= AXIS_DEBUG_TIMEOUT_BYTE;
                out_last  <= 1'b1;
            end else if (i_m_axis_tready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant <= arb_grant;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && g_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end else if (tmo) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
